// File: rtl/avl_pkg.sv
// Shared types and constants for the Avalon-MM SRAM responder.
package avl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_e;

  localparam int AVL_BE_W = 4;
  localparam int BYTE_OFS = 2;

endpackage

// File: rtl/avl_sram_slave.sv
// Avalon-MM responder in front of a single-port synchronous SRAM: zero-wait writes, stalled reads.
// Define AVL_SRAM_RANGE_CHK_EN to reject out-of-range addresses and raise a sticky err.
module avl_sram_slave
  import avl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_AW     = 12,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
  input  logic [AVL_BE_W-1:0]   byteenable,
  input  logic                  read,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  waitrequest,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [AVL_BE_W-1:0]   mem_be,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err
);

  state_e                state_q;
  logic [2:0]            cnt_q;
  logic [DATA_WIDTH-1:0] readdata_q;
  logic                  out_of_range;
  logic                  idle_rd;
  logic                  idle_wr;

  // Byte lanes are chosen by byteenable, so the low address bits never matter.
  logic unused_addr_lo;
  assign unused_addr_lo = ^address[BYTE_OFS-1:0];

`ifdef AVL_SRAM_RANGE_CHK_EN
  logic err_q;

  assign out_of_range = |address[ADDR_WIDTH-1:MEM_AW+BYTE_OFS];

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE && (read || write) && out_of_range) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  // Upper address bits alias onto the SRAM when range checking is not built in.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[ADDR_WIDTH-1:MEM_AW+BYTE_OFS];
  assign out_of_range   = 1'b0;
  assign err            = 1'b0;
`endif

  assign mem_addr  = address[MEM_AW+BYTE_OFS-1:BYTE_OFS];
  assign mem_wdata = writedata;
  assign mem_be    = byteenable;

  // Read wins over a simultaneous write; the write is dropped, not deferred.
  assign idle_rd = (state_q == IDLE) && read;
  assign idle_wr = (state_q == IDLE) && !read && write;

  // Strobes and the stall are decoded from state so a write completes in the cycle it is seen.
  assign mem_re      = !reset && idle_rd && !out_of_range;
  assign mem_we      = !reset && idle_wr && (|byteenable) && !out_of_range;
  assign waitrequest = reset || idle_rd || (state_q == RD_WAIT);
  assign readdata    = readdata_q;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      readdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (read) begin
            if (out_of_range) begin
              readdata_q <= '0;
              state_q    <= RD_DONE;
            end else begin
              cnt_q   <= 3'(RD_LAT - 1);
              state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            readdata_q <= mem_rdata;
            state_q    <= RD_DONE;
          end
        end
        RD_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
